fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-side controller of the dual-clock FIFO; the consumer end of the write-side pointer/sync path.
//  Runs entirely in the read clock domain. Inputs: gray write pointer, already synchronised into r_clk.
//  Outputs: gray read pointer for the write side, read address to the dual-port RAM, valid/ready output stream.
//  Tracks occupancy; generates empty and almost-empty flags.
// PARAMETERS
//  ADDR_SIZE   4  RAM address width; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
//  DATA_SIZE   8  word width.
//  AEMPTY_LVL  2  r_almost_empty asserted while occupancy <= AEMPTY_LVL.
// PORTS
//  r_clk           in   1            read-domain clock; all state on posedge.
//  rst             in   1            synchronous, active-high reset.
//  r_wptr_sync     in   ADDR_SIZE+1  gray write pointer, already synchronised to r_clk.
//  r_ptr           out  ADDR_SIZE+1  gray read pointer (registered), sent to write-side sync.
//  r_addr          out  ADDR_SIZE    RAM read address = binary read pointer [ADDR_SIZE-1:0].
//  r_mem_en        out  1            RAM read strobe; mem_rdata valid one cycle later.
//  mem_rdata       in   DATA_SIZE    RAM read data; 1-cycle registered latency.
//  r_data          out  DATA_SIZE    output word (registered).
//  r_valid         out  1            r_data holds an unconsumed word.
//  r_ready         in   1            consumer accepts r_data when r_valid & r_ready.
//  r_empty         out  1            no words left in RAM: r_ptr == r_wptr_sync.
//  r_almost_empty  out  1            occupancy <= AEMPTY_LVL.
//  r_count         out  ADDR_SIZE+1  occupancy = gray2bin(r_wptr_sync) - rbin, modulo 2**(ADDR_SIZE+1).
// BEHAVIOUR
//  Reset (rst high at posedge):
//   - rbin=0, r_ptr=0, r_data=0, r_valid=0, state=IDLE.
//   - Any in-flight RAM read is discarded.
//  Flags and count (combinational from registers and r_wptr_sync):
//   - r_empty, r_almost_empty and r_count follow the definitions above.
//   - r_count range is 0..2**ADDR_SIZE; the value 2**ADDR_SIZE means full.
//  Pointer update:
//   - r_mem_en=1 increments rbin at the same posedge.
//   - r_ptr = rbin_next ^ (rbin_next>>1), registered.
//   - Wraps naturally at 2**(ADDR_SIZE+1).
//  r_mem_en = ~r_empty & issue_ok; r_addr is the current rbin, not the incremented value.
//  FSM:
//   - IDLE:  r_valid=0; issue_ok=1; if ~r_empty -> FETCH.
//   - FETCH: issue_ok=0; capture mem_rdata into r_data; r_valid<=1 -> HOLD.
//   - HOLD:  r_valid=1; issue_ok=r_ready.
//      - r_ready & ~r_empty: read issued, r_valid<=0 -> FETCH.
//      - r_ready & r_empty: r_valid<=0 -> IDLE.
//      - ~r_ready: stay; r_data stable.
//  Latency: r_wptr_sync advance while IDLE -> r_mem_en same cycle -> r_valid 2 cycles later.
//  Throughput: one word per 2 cycles sustained (one bubble per word).
//  Backpressure: r_data and r_valid are held while ~r_ready; r_ready is ignored when r_valid=0.
//  Simultaneous events:
//   - r_wptr_sync may change in any cycle.
//   - A new word arriving in the same cycle as the last pop is seen from the next cycle.
//  No underflow: a read is never issued while r_empty; the pointer never passes r_wptr_sync.
//  Reset mid-FETCH or mid-HOLD: the word is dropped; r_valid falls at that posedge.
// TESTING
//  1. Reset, r_wptr_sync=0:
//     r_empty=1, r_count=0, r_almost_empty=1, r_valid=0, r_ptr=0, r_mem_en=0.
//  2. Single word, mem_rdata=8'hA5:
//     r_wptr_sync 0->5'b00001 -> r_mem_en=1 with r_addr=0 that cycle.
//     r_valid=1 with r_data=A5 two cycles later; r_ptr=00001; r_empty=1 after the issue.
//  3. Backpressure: r_ready=0 for 5 cycles with r_valid=1 -> r_data stable, r_mem_en=0.
//     Then r_ready=1 -> word popped next posedge.
//  4. Full and drain: r_wptr_sync=gray(16)=5'b11000, rbin=0 -> r_count=16.
//     Drain with r_ready=1: 16 words, addresses 0..15 in order; r_empty=1 after the last issue.
//  5. Wrap: pre-advance rbin to 30, write 4 words (wptr gray(2)=00011).
//     Addresses 14,15,0,1; r_ptr ends at 00011; r_count 4->0 via 3,2 (r_almost_empty from 2).
//  6. Reset in FETCH: rst at the capture posedge -> r_valid=0, r_ptr=0, state IDLE, no stale word delivered.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - read-side controller of the dual-clock FIFO
// Tracks the read pointer, issues RAM reads and presents words on a valid/ready stream.
module fifo_read_ctrl #(
  parameter int ADDR_SIZE  = 4,
  parameter int DATA_SIZE  = 8,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                 r_clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE:0]   r_wptr_sync,
  output logic [ADDR_SIZE:0]   r_ptr,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic                 r_mem_en,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output logic [ADDR_SIZE:0]   r_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [ADDR_SIZE:0] AEMPTY_CMP = AEMPTY_LVL[ADDR_SIZE:0];

  state_t             state, state_next;
  logic [ADDR_SIZE:0] rbin, rbin_next, wbin;
  logic               issue_ok, valid_next, capture;

  // Gray to binary: each bit is the XOR of itself and all higher gray bits.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      wbin[i] = ^(r_wptr_sync >> i);
    end
  end

  assign r_count        = wbin - rbin;
  assign r_empty        = (r_ptr == r_wptr_sync);
  assign r_almost_empty = (r_count <= AEMPTY_CMP);

  always_comb begin
    state_next = state;
    issue_ok   = 1'b0;
    valid_next = r_valid;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        issue_ok = 1'b1;
        if (!r_empty) state_next = FETCH;
      end
      FETCH: begin
        capture    = 1'b1;
        valid_next = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        issue_ok = r_ready;
        if (r_ready) begin
          valid_next = 1'b0;
          state_next = r_empty ? IDLE : FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The address is the pre-increment pointer; the RAM returns that word next cycle.
  assign r_mem_en  = ~r_empty & issue_ok;
  assign r_addr    = rbin[ADDR_SIZE-1:0];
  assign rbin_next = rbin + {{ADDR_SIZE{1'b0}}, r_mem_en};

  always_ff @(posedge r_clk) begin
    if (rst) begin
      rbin    <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      state   <= IDLE;
    end else begin
      rbin    <= rbin_next;
      r_ptr   <= rbin_next ^ (rbin_next >> 1);
      r_valid <= valid_next;
      state   <= state_next;
      if (capture) r_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - self-checking bench for fifo_read_ctrl
// Queue-based occupancy/stream model, directed scenarios, then randomized traffic.
module tb_fifo_read_ctrl;

  logic       r_clk = 1'b0;
  logic       rst;
  logic [4:0] r_wptr_sync;
  logic [4:0] r_ptr;
  logic [3:0] r_addr;
  logic       r_mem_en;
  logic [7:0] mem_rdata;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ready;
  logic       r_empty;
  logic       r_almost_empty;
  logic [4:0] r_count;

  fifo_read_ctrl #(.ADDR_SIZE(4), .DATA_SIZE(8), .AEMPTY_LVL(2)) dut (
    .r_clk(r_clk), .rst(rst), .r_wptr_sync(r_wptr_sync), .r_ptr(r_ptr),
    .r_addr(r_addr), .r_mem_en(r_mem_en), .mem_rdata(mem_rdata), .r_data(r_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_empty(r_empty),
    .r_almost_empty(r_almost_empty), .r_count(r_count)
  );

  always #5 r_clk = ~r_clk;

  logic [7:0] mem [16];
  always @(posedge r_clk) if (r_mem_en) mem_rdata <= mem[r_addr];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: words written but not yet read, plus one in-flight word and one held word.
  logic [4:0] wbin = '0;
  logic [4:0] rbin_m = '0;
  logic [7:0] wq [$];
  bit         inflight_m = 1'b0;
  bit         valid_m = 1'b0;
  logic [7:0] fly_data = '0;
  logic [7:0] data_m = '0;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] m_cnt();
    return wbin - rbin_m;
  endfunction

  function automatic bit m_issue();
    return (m_cnt() != 5'd0) && !inflight_m && (!valid_m || r_ready);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge r_clk) begin
    if (rst) begin
      rbin_m     <= '0;
      inflight_m <= 1'b0;
      valid_m    <= 1'b0;
      data_m     <= '0;
    end else begin
      if (inflight_m) begin
        valid_m <= 1'b1;
        data_m  <= fly_data;
      end else if (valid_m && r_ready) begin
        valid_m <= 1'b0;
      end
      inflight_m <= m_issue();
      if (m_issue()) begin
        if (wq.size() != 0) fly_data <= wq.pop_front();
        rbin_m <= rbin_m + 5'd1;
      end
    end
  end

  always @(negedge r_clk) begin
    if (chk_en) begin
      chk("count", 32'(r_count), 32'(m_cnt()));
      chk("empty", 32'(r_empty), 32'(m_cnt() == 5'd0));
      chk("almost_empty", 32'(r_almost_empty), 32'(m_cnt() <= 5'd2));
      chk("mem_en", 32'(r_mem_en), 32'(m_issue()));
      if (m_issue()) chk("addr", 32'(r_addr), 32'(rbin_m[3:0]));
      chk("ptr", 32'(r_ptr), 32'(gray(rbin_m)));
      chk("valid", 32'(r_valid), 32'(valid_m));
      if (valid_m) chk("data", 32'(r_data), 32'(data_m));
    end
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    wq.push_back(d);
    wbin = wbin + 5'd1;
    r_wptr_sync = gray(wbin);
  endtask

  task automatic start_reset();
    rst = 1'b1;
    wbin = '0;
    wq.delete();
    r_wptr_sync = '0;
  endtask

  task automatic drain(input int n_exp, input string tag, output int n);
    n = 0;
    for (int c = 0; c < 80 && n < n_exp; c++) begin
      @(negedge r_clk);
      if (r_mem_en) n++;
      tick();
    end
    chk({tag, "_issues"}, 32'(n), 32'(n_exp));
  endtask

  int n;
  int exp_a [4] = '{14, 15, 0, 1};
  int exp_c [4] = '{4, 3, 2, 1};
  int exp_ae [4] = '{0, 0, 1, 1};

  initial begin
    start_reset();
    r_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge r_clk);
    chk("rst_empty", 32'(r_empty), 32'd1);
    chk("rst_count", 32'(r_count), 32'd0);
    chk("rst_aempty", 32'(r_almost_empty), 32'd1);
    chk("rst_valid", 32'(r_valid), 32'd0);
    chk("rst_ptr", 32'(r_ptr), 32'd0);
    chk("rst_mem_en", 32'(r_mem_en), 32'd0);

    // Single word
    tick();
    push(8'hA5);
    @(negedge r_clk);
    chk("single_mem_en", 32'(r_mem_en), 32'd1);
    chk("single_addr", 32'(r_addr), 32'd0);
    tick();
    @(negedge r_clk);
    chk("single_empty", 32'(r_empty), 32'd1);
    chk("single_ptr", 32'(r_ptr), 32'd1);
    chk("single_valid_early", 32'(r_valid), 32'd0);
    tick();
    @(negedge r_clk);
    chk("single_valid", 32'(r_valid), 32'd1);
    chk("single_data", 32'(r_data), 32'hA5);

    // Backpressure
    repeat (5) begin
      tick();
      @(negedge r_clk);
      chk("bp_data", 32'(r_data), 32'hA5);
      chk("bp_valid", 32'(r_valid), 32'd1);
      chk("bp_mem_en", 32'(r_mem_en), 32'd0);
    end
    tick();
    r_ready = 1'b1;
    @(negedge r_clk);
    tick();
    @(negedge r_clk);
    chk("bp_popped", 32'(r_valid), 32'd0);

    // Full and drain
    tick();
    start_reset();
    for (int i = 0; i < 16; i++) push(8'($urandom));
    tick();
    @(negedge r_clk);
    chk("full_count", 32'(r_count), 32'd16);
    chk("full_wptr", 32'(r_wptr_sync), 32'b11000);
    tick();
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 80 && n < 16; c++) begin
      @(negedge r_clk);
      if (r_mem_en) begin
        chk("drain_addr", 32'(r_addr), 32'(n));
        n++;
      end
      tick();
    end
    chk("drain_issues", 32'(n), 32'd16);
    @(negedge r_clk);
    chk("drain_empty", 32'(r_empty), 32'd1);
    repeat (4) tick();

    // Wrap: bring the read pointer to 30, then write 4 words
    for (int i = 0; i < 14; i++) push(8'($urandom));
    drain(14, "pre_wrap", n);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) push(8'($urandom));
    chk("wrap_wptr", 32'(r_wptr_sync), 32'b00011);
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge r_clk);
      if (r_mem_en) begin
        chk("wrap_addr", 32'(r_addr), 32'(exp_a[n]));
        chk("wrap_count", 32'(r_count), 32'(exp_c[n]));
        chk("wrap_aempty", 32'(r_almost_empty), 32'(exp_ae[n]));
        n++;
      end
      tick();
    end
    chk("wrap_issues", 32'(n), 32'd4);
    @(negedge r_clk);
    chk("wrap_ptr", 32'(r_ptr), 32'b00011);
    chk("wrap_count_end", 32'(r_count), 32'd0);
    repeat (4) tick();

    // Reset while fetching
    push(8'h3C);
    @(negedge r_clk);
    chk("rf_issue", 32'(r_mem_en), 32'd1);
    tick();
    start_reset();
    tick();
    @(negedge r_clk);
    chk("rf_valid", 32'(r_valid), 32'd0);
    chk("rf_ptr", 32'(r_ptr), 32'd0);
    chk("rf_mem_en", 32'(r_mem_en), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      @(negedge r_clk);
      chk("rf_no_stale", 32'(r_valid), 32'd0);
    end

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (rst) rst = 1'b0;
      r_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        start_reset();
      end else if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) begin
          if (m_cnt() < 5'd16) push(8'($urandom));
        end
      end
    end
    tick();
    rst = 1'b0;
    r_ready = 1'b1;
    repeat (60) tick();
    chk("final_empty", 32'(r_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
